// File: rtl/sseg_pkg.sv
// Shared constants, FSM state type and anode decode for the seven-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sseg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  // Digit index to active-low one-hot anode enable.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    an_onehot = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot/blank cycle counter: counts up to the selected limit, flags terminal count, reloads zero.
// Latency: tc_o is combinational from the counter register; the counter restarts on the tc edge.
// Backpressure: none; free-running whenever out of reset.
module sseg_slot_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_slot_i,
  output logic tc_o
);

  // A zero-length blank phase collapses to a single-cycle limit so the reset-time
  // BLANK state still exits on the first edge.
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] limit;

  // Terminal-count compare and next count; the counter never passes its limit.
  always_comb begin
    limit = sel_slot_i ? SLOT_LAST : BLANK_LAST;
    tc_o  = (cnt_q == limit);
    cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode seven-segment scanner with inter-digit blanking and per-frame capture.
// Latency: an/sseg/frame_tick are registered and change on the same edge as the FSM state.
// Backpressure: none; inputs are sampled once per frame, changes in between are ignored.
// Optional PWM dimming is compiled in with SSEG_BRIGHTNESS_EN.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SSEG_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  input  logic [7:0] dig_0,
  input  logic [7:0] dig_1,
  input  logic [7:0] dig_2,
  input  logic [7:0] dig_3,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] shadow_q [NUM_DIGITS];
  logic [7:0] shadow_d [NUM_DIGITS];
  logic [7:0] dig_w    [NUM_DIGITS];
  logic [3:0] an_q, an_d;
  logic [7:0] sseg_q, sseg_d;
  logic       tick_q, tick_d;
  logic       tc;
  logic       enter_on;
  logic       capture;
`ifdef SSEG_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;
`endif

  assign dig_w[0] = dig_0;
  assign dig_w[1] = dig_1;
  assign dig_w[2] = dig_2;
  assign dig_w[3] = dig_3;

  sseg_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .sel_slot_i (state_q == ST_ON),
    .tc_o       (tc)
  );

  // Next state and digit index; ON->ON counts as entering ON when blanking is disabled.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    enter_on = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (tc) begin
          state_d  = ST_ON;
          enter_on = 1'b1;
        end
      end
      ST_ON: begin
        if (tc) begin
          idx_d = idx_q + 2'd1;
          if (BLANK_CYCLES == 0) begin
            state_d  = ST_ON;
            enter_on = 1'b1;
          end else begin
            state_d = ST_BLANK;
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Frame capture and output decode; sseg reads the post-capture shadow so digit 0 never shows a stale frame.
  always_comb begin
    capture = enter_on && (idx_d == 2'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_d[i] = capture ? dig_w[i] : shadow_q[i];
    end
    tick_d = capture;
    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    if (state_d == ST_ON) begin
      an_d   = an_onehot(idx_d);
      sseg_d = shadow_d[idx_d];
    end
`ifdef SSEG_BRIGHTNESS_EN
    // Gate against the pwm value the register will hold, so the lit window tracks pwm_q exactly.
    pwm_d    = pwm_q + 4'd1;
    bright_d = capture ? brightness : bright_q;
    if ((state_d == ST_ON) && (pwm_d > bright_d)) begin
      an_d = AN_OFF;
    end
`endif
  end

  // FSM, index, frame shadows and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      sseg_q  <= SEG_BLANK;
      tick_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= SEG_BLANK;
      end
`ifdef SSEG_BRIGHTNESS_EN
      pwm_q    <= 4'd0;
      bright_q <= 4'hF;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
`ifdef SSEG_BRIGHTNESS_EN
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
`endif
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (SLOT=8/BLANK=2 and SLOT=8/BLANK=0) against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sseg_scan_driver;

  localparam int SLOT = 8;
  localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dig [4];
  logic [3:0] an_a, an_b;
  logic [7:0] sseg_a, sseg_b;
  logic       tick_a, tick_b;
`ifdef SSEG_BRIGHTNESS_EN
  logic [3:0] brightness_drv = 4'hF;
  logic [3:0] br_a, br_b;
`endif

  int checks = 0;
  int failures = 0;
  int t_cyc;
  bit mon_en = 1'b0;

  logic [7:0] sh_a [4];
  logic [7:0] sh_b [4];
  logic [3:0] exp_an_a, exp_an_b;
  logic [7:0] exp_sseg_a, exp_sseg_b;
  logic       exp_tick_a, exp_tick_b;

  always #5 clk = ~clk;

  sseg_scan_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
`ifdef SSEG_BRIGHTNESS_EN
    .brightness(brightness_drv),
`endif
    .dig_0(dig[0]), .dig_1(dig[1]), .dig_2(dig[2]), .dig_3(dig[3]),
    .an(an_a), .sseg(sseg_a), .frame_tick(tick_a)
  );

  sseg_scan_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
`ifdef SSEG_BRIGHTNESS_EN
    .brightness(brightness_drv),
`endif
    .dig_0(dig[0]), .dig_1(dig[1]), .dig_2(dig[2]), .dig_3(dig[3]),
    .an(an_b), .sseg(sseg_b), .frame_tick(tick_b)
  );

  // Edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) t_cyc <= 0;
    else       t_cyc <= t_cyc + 1;
  end

  // Timeline reference: after a lead-in (the blank phase, or the single reset-held cycle when
  // blanking is off) the display repeats slots of SLOT lit cycles plus `blank` dark cycles.
  function automatic void ref_outputs(input int t, input int blank,
                                      output int digit, output bit lit, output bit tick);
    int lead, p, u;
    lead  = (blank == 0) ? 1 : blank;
    p     = SLOT + blank;
    u     = t - lead;
    digit = 0;
    lit   = 1'b0;
    tick  = 1'b0;
    if (u >= 0) begin
      digit = (u / p) % 4;
      lit   = (u % p) < SLOT;
      tick  = ((u % p) == 0) && (digit == 0);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      sh_a[i] = 8'hFF;
      sh_b[i] = 8'hFF;
    end
`ifdef SSEG_BRIGHTNESS_EN
    br_a = 4'hF;
    br_b = 4'hF;
`endif
  endfunction

  function automatic void model_step();
    int  d;
    bit  l, k;
    ref_outputs(t_cyc, 2, d, l, k);
    if (k) begin
      for (int i = 0; i < 4; i++) sh_a[i] = dig[i];
`ifdef SSEG_BRIGHTNESS_EN
      br_a = brightness_drv;
`endif
    end
    exp_tick_a = k;
    exp_an_a   = l ? AN_SEQ[d] : 4'hF;
    exp_sseg_a = l ? sh_a[d] : 8'hFF;
`ifdef SSEG_BRIGHTNESS_EN
    if (l && ((t_cyc % 16) > int'(br_a))) exp_an_a = 4'hF;
`endif
    ref_outputs(t_cyc, 0, d, l, k);
    if (k) begin
      for (int i = 0; i < 4; i++) sh_b[i] = dig[i];
`ifdef SSEG_BRIGHTNESS_EN
      br_b = brightness_drv;
`endif
    end
    exp_tick_b = k;
    exp_an_b   = l ? AN_SEQ[d] : 4'hF;
    exp_sseg_b = l ? sh_b[d] : 8'hFF;
`ifdef SSEG_BRIGHTNESS_EN
    if (l && ((t_cyc % 16) > int'(br_b))) exp_an_b = 4'hF;
`endif
  endfunction

  // Scoreboard: every cycle out of reset, both instances against the timeline model.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      model_step();
      checks++;
      if ({an_a, sseg_a, tick_a} !== {exp_an_a, exp_sseg_a, exp_tick_a}) begin
        failures++;
        $display("FAIL scan_a t=%0d an/sseg/tick=%b/%h/%b expected %b/%h/%b",
                 t_cyc, an_a, sseg_a, tick_a, exp_an_a, exp_sseg_a, exp_tick_a);
      end
      checks++;
      if ({an_b, sseg_b, tick_b} !== {exp_an_b, exp_sseg_b, exp_tick_b}) begin
        failures++;
        $display("FAIL scan_b t=%0d an/sseg/tick=%b/%h/%b expected %b/%h/%b",
                 t_cyc, an_b, sseg_b, tick_b, exp_an_b, exp_sseg_b, exp_tick_b);
      end
      checks++;
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
        failures++;
        $display("FAIL one_anode t=%0d an_a=%b an_b=%b expected at most one low", t_cyc, an_a, an_b);
      end
    end
  end

  task automatic test_reset();
    int lit, dark;
    dig = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({an_a, sseg_a, tick_a} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL reset_a an/sseg/tick=%b/%h/%b expected 1111/ff/0", an_a, sseg_a, tick_a);
    end
    checks++;
    if ({an_b, sseg_b, tick_b} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL reset_b an/sseg/tick=%b/%h/%b expected 1111/ff/0", an_b, sseg_b, tick_b);
    end
    #1 reset = 1'b0;
    mon_en = 1'b1;
    for (int n = 0; n < 20 && tick_a !== 1'b1; n++) @(negedge clk);
    checks++;
    if (tick_a !== 1'b1 || t_cyc != 2 || an_a !== 4'b1110 || sseg_a !== 8'hC0) begin
      failures++;
      $display("FAIL first_frame t=%0d tick=%b an=%b sseg=%h expected t=2 tick=1 an=1110 sseg=c0",
               t_cyc, tick_a, an_a, sseg_a);
    end
    lit = 0;
    dark = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (an_a === 4'b1110 && sseg_a === 8'hC0) lit++;
      if (an_a === 4'hF) dark++;
    end
    checks++;
    if (lit != 8 || dark != 2) begin
      failures++;
      $display("FAIL digit0_slot lit=%0d dark=%0d expected lit=8 dark=2", lit, dark);
    end
    @(negedge clk);
    checks++;
    if (an_a !== 4'b1101 || sseg_a !== 8'hF9) begin
      failures++;
      $display("FAIL digit1_start an=%b sseg=%h expected 1101/f9", an_a, sseg_a);
    end
  endtask

  task automatic test_frame_period();
    int ta[$], tb[$];
    logic [3:0] seq[$];
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (tick_a === 1'b1) ta.push_back(t_cyc);
      if (tick_b === 1'b1) tb.push_back(t_cyc);
      if (ta.size() > 0 && an_a !== 4'hF && (seq.size() == 0 || seq[$] !== an_a)) seq.push_back(an_a);
    end
    checks++;
    if (ta.size() < 2 || ta[1] - ta[0] != 40) begin
      failures++;
      $display("FAIL period_a ticks=%0d gap=%0d expected gap 40", ta.size(), (ta.size() > 1) ? ta[1] - ta[0] : -1);
    end
    checks++;
    if (tb.size() < 2 || tb[1] - tb[0] != 32) begin
      failures++;
      $display("FAIL period_b ticks=%0d gap=%0d expected gap 32", tb.size(), (tb.size() > 1) ? tb[1] - tb[0] : -1);
    end
    checks++;
    if (seq.size() < 5 || seq[0] !== 4'b1110 || seq[1] !== 4'b1101 || seq[2] !== 4'b1011 ||
        seq[3] !== 4'b0111 || seq[4] !== 4'b1110) begin
      failures++;
      $display("FAIL an_order got %0d entries first=%b expected 1110,1101,1011,0111,1110",
               seq.size(), (seq.size() > 0) ? seq[0] : 4'hx);
    end
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    #1 dig = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    n = 0;
    @(negedge clk);
    while (tick_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    while (an_a !== 4'b1101 && n < 200) begin @(negedge clk); n++; end
    #1 dig[2] = 8'h88;
    while (an_a !== 4'b1011 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (an_a !== 4'b1011 || sseg_a !== 8'hA4) begin
      failures++;
      $display("FAIL hold_old an=%b sseg=%h expected 1011/a4", an_a, sseg_a);
    end
    while (tick_a !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (an_a !== 4'b1011 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (an_a !== 4'b1011 || sseg_a !== 8'h88) begin
      failures++;
      $display("FAIL hold_new an=%b sseg=%h expected 1011/88", an_a, sseg_a);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (an_a !== 4'b1011 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (an_a !== 4'b1011) begin
      failures++;
      $display("FAIL mid_slot an=%b expected 1011", an_a);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (an_a !== 4'hF || sseg_a !== 8'hFF || tick_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an=%b sseg=%h tick=%b expected 1111/ff/0", an_a, sseg_a, tick_a);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (tick_a !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (tick_a !== 1'b1 || t_cyc != 2 || an_a !== 4'b1110 || sseg_a !== dig[0]) begin
      failures++;
      $display("FAIL restart t=%0d tick=%b an=%b sseg=%h expected t=2 tick=1 an=1110 sseg=%h",
               t_cyc, tick_a, an_a, sseg_a, dig[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(7) == 0) dig[$urandom_range(3)] = 8'($urandom);
`ifdef SSEG_BRIGHTNESS_EN
      if ($urandom_range(15) == 0) brightness_drv = 4'($urandom);
`endif
    end
  endtask

`ifdef SSEG_BRIGHTNESS_EN
  task automatic test_brightness();
    int n, bad;
    @(negedge clk);
    #1 brightness_drv = 4'd3;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (tick_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((an_b !== 4'hF) !== ((t_cyc % 16) <= 3)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL duty_3 bad_cycles=%0d expected 0", bad);
    end
    #1 brightness_drv = 4'd15;
    n = 0;
    @(negedge clk);
    while (tick_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an_b === 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL duty_15 dark_cycles=%0d expected 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_period();
    test_hold();
    test_async_reset();
    test_random();
`ifdef SSEG_BRIGHTNESS_EN
    test_brightness();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
